// File: rtl/fifo_buffer.sv
// Dual-source show-ahead FIFO with wrap-bit pointers and occupancy flags.
// Source A wins write arbitration; error flags are sticky until clear_err.
module fifo_buffer #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int AF_LEVEL = 56,
    parameter int AE_LEVEL = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_a_en,
    input  logic [DATA_W-1:0] wr_a_data,
    input  logic              wr_b_en,
    input  logic [DATA_W-1:0] wr_b_data,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clear_err,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   occupancy,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic              conflict
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_V    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              cfl_q, cfl_d;

    logic              wr_req;
    logic              rd_ok;
    logic              wr_ok;
    logic [DATA_W-1:0] wr_word;

    // Status derives only from registered pointers.
    assign occupancy    = wr_ptr_q - rd_ptr_q;
    assign full         = (occupancy == DEPTH_V);
    assign empty        = (occupancy == '0);
    assign almost_full  = (occupancy >= AF_V);
    assign almost_empty = (occupancy <= AE_V);
    assign rd_data      = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign conflict  = cfl_q;

    assign wr_req  = wr_a_en | wr_b_en;
    assign wr_word = wr_a_en ? wr_a_data : wr_b_data;
    assign rd_ok   = rd_en & ~empty & ~flush;
    assign wr_ok   = wr_req & (~full | (rd_en & ~empty)) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // A new event outranks clear_err in the same cycle.
    always_comb begin
        ovf_d = (ovf_q & ~clear_err)
              | (~flush & wr_req & full & ~rd_en);
        udf_d = (udf_q & ~clear_err) | (~flush & rd_en & empty);
        cfl_d = (cfl_q & ~clear_err) | (~flush & wr_a_en & wr_b_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            cfl_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            cfl_q    <= cfl_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed bench for fifo_buffer at default parameters.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_fifo_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_a_en, wr_b_en, rd_en, flush, clear_err;
    logic [7:0] wr_a_data, wr_b_data;
    logic [7:0] rd_data;
    logic [6:0] occupancy;
    logic       full, empty, almost_full, almost_empty;
    logic       overflow, underflow, conflict;

    int checks   = 0;
    int failures = 0;

    fifo_buffer dut (
        .clk(clk), .rst(rst),
        .wr_a_en(wr_a_en), .wr_a_data(wr_a_data),
        .wr_b_en(wr_b_en), .wr_b_data(wr_b_data),
        .rd_en(rd_en), .flush(flush), .clear_err(clear_err),
        .rd_data(rd_data), .occupancy(occupancy),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic a_en, input logic [7:0] a_d,
                       input logic b_en, input logic [7:0] b_d,
                       input logic rd, input logic fl, input logic ce);
        wr_a_en = a_en; wr_a_data = a_d;
        wr_b_en = b_en; wr_b_data = b_d;
        rd_en = rd; flush = fl; clear_err = ce;
        @(posedge clk);
        #1;
        wr_a_en = 0; wr_b_en = 0; rd_en = 0; flush = 0; clear_err = 0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_occ"}, 32'(occupancy), 0);
        chk({pfx, "_empty"}, 32'(empty), 1);
        chk({pfx, "_ae"}, 32'(almost_empty), 1);
        chk({pfx, "_full"}, 32'(full), 0);
        chk({pfx, "_af"}, 32'(almost_full), 0);
        chk({pfx, "_rdata"}, 32'(rd_data), 0);
        chk({pfx, "_ovf"}, 32'(overflow), 0);
        chk({pfx, "_udf"}, 32'(underflow), 0);
        chk({pfx, "_cfl"}, 32'(conflict), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] v;
        bit seen0, seen1;
        int maxocc;

        rst = 1; wr_a_en = 0; wr_b_en = 0; rd_en = 0;
        flush = 0; clear_err = 0; wr_a_data = 0; wr_b_data = 0;
        #2;
        chk_reset_vals("rst");
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Fill with 0x00..0x3F and watch flag thresholds.
        for (int i = 0; i < 64; i++) begin
            cyc(1, 8'(i), 0, 0, 0, 0, 0);
            if (i == 7)  chk("ae_at8", 32'(almost_empty), 1);
            if (i == 8)  chk("ae_at9", 32'(almost_empty), 0);
            if (i == 54) chk("af_at55", 32'(almost_full), 0);
            if (i == 55) chk("af_at56", 32'(almost_full), 1);
            if (i == 62) chk("full_at63", 32'(full), 0);
        end
        chk("fill_occ", 32'(occupancy), 64);
        chk("fill_full", 32'(full), 1);
        cyc(1, 8'hFF, 0, 0, 0, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_occ", 32'(occupancy), 64);
        chk("ovf_head", 32'(rd_data), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("ovf_clear", 32'(overflow), 0);

        // Full with simultaneous read and write.
        cyc(1, 8'hAA, 0, 0, 1, 0, 0);
        chk("fullrw_occ", 32'(occupancy), 64);
        chk("fullrw_ovf", 32'(overflow), 0);
        chk("fullrw_head", 32'(rd_data), 1);

        // Drain: 0x01..0x3F then 0xAA.
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("drain_%0d", i), 32'(rd_data),
                (i < 63) ? 32'(i + 1) : 32'hAA);
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_udf0", 32'(underflow), 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("udf_set", 32'(underflow), 1);
        chk("udf_occ", 32'(occupancy), 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("udf_clr_vs_set", 32'(underflow), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("udf_clear", 32'(underflow), 0);

        // Dual write conflict on empty FIFO.
        cyc(1, 8'h11, 1, 8'h22, 0, 0, 0);
        chk("cfl_rdata", 32'(rd_data), 8'h11);
        chk("cfl_occ", 32'(occupancy), 1);
        chk("cfl_flag", 32'(conflict), 1);
        chk("cfl_empty", 32'(empty), 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("cfl_drain", 32'(empty), 1);
        chk("cfl_cleared", 32'(conflict), 0);

        // Source B alone; then read+write on empty.
        cyc(0, 0, 1, 8'h5C, 0, 0, 0);
        chk("wb_rdata", 32'(rd_data), 8'h5C);
        chk("wb_cfl", 32'(conflict), 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 8'h33, 0, 0, 1, 0, 0);
        chk("emprw_occ", 32'(occupancy), 1);
        chk("emprw_udf", 32'(underflow), 1);
        chk("emprw_rdata", 32'(rd_data), 8'h33);
        cyc(0, 0, 0, 0, 1, 0, 1);

        // Wrap: interleaved write/read pairs with gaps.
        seen0 = 0; seen1 = 0; maxocc = 0;
        for (int i = 0; i < 200; i++) begin
            v = 8'($urandom);
            q.push_back(v);
            cyc(1, v, 0, 0, 0, 0, 0);
            if (dut.wr_ptr_q[6]) seen1 = 1; else seen0 = 1;
            if (32'(occupancy) > maxocc) maxocc = 32'(occupancy);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            chk("wrap_occ", 32'(occupancy), 32'(q.size()));
            chk("wrap_data", 32'(rd_data), 32'(q[0]));
            void'(q.pop_front());
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        chk("wrap_maxocc", 32'(maxocc <= 64), 1);
        chk("wrap_msb", 32'(seen0 && seen1), 1);
        chk("wrap_empty", 32'(empty), 1);

        // Flush at occupancy 30 with concurrent write.
        for (int i = 0; i < 30; i++) cyc(1, 8'(i + 8'h40), 0, 0, 0, 0, 0);
        chk("pre_flush_occ", 32'(occupancy), 30);
        cyc(1, 8'h77, 0, 0, 1, 1, 0);
        chk("flush_occ", 32'(occupancy), 0);
        chk("flush_empty", 32'(empty), 1);
        cyc(1, 8'h66, 0, 0, 0, 0, 0);
        chk("post_flush_head", 32'(rd_data), 8'h66);

        // Reset mid-burst, asynchronously.
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("pre_rst_udf", 32'(underflow), 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'(i + 8'h90), 0, 0, 0, 0, 0);
        wr_a_en = 1; wr_a_data = 8'hEE;
        #2;
        rst = 1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        chk_reset_vals("midrst_edge");
        wr_a_en = 0;
        rst = 0;
        cyc(1, 8'h5A, 0, 0, 0, 0, 0);
        chk("resume_rdata", 32'(rd_data), 8'h5A);
        chk("resume_occ", 32'(occupancy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of each stored word.
REQ-002 Parameter ADDR_W, default 6: address width; DEPTH = 2**ADDR_W (64 at default).
REQ-003 Parameter AF_LEVEL, default 56: occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 8: occupancy at or below which almost_empty asserts.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 wr_a_en  in  1  write request, source A (transmit side).
REQ-009 wr_a_data  in  DATA_W  source A write word.
REQ-010 wr_b_en  in  1  write request, source B (receive side).
REQ-011 wr_b_data  in  DATA_W  source B write word.
REQ-012 rd_en  in  1  pop request for the head word.
REQ-013 flush  in  1  synchronous clear of contents and pointers.
REQ-014 clear_err  in  1  synchronous clear of sticky error flags.
REQ-015 rd_data  out  DATA_W  head word, show-ahead (combinational from storage at read pointer).
REQ-016 occupancy  out  ADDR_W+1  stored word count, 0..DEPTH.
REQ-017 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-018 overflow, underflow, conflict  out  1 each  sticky error flags.

Function
REQ-019 Write and read pointers SHALL be ADDR_W+1 bits; storage is indexed by the low ADDR_W bits; the MSB distinguishes wrap.
REQ-020 occupancy SHALL equal wr_ptr - rd_ptr modulo 2**(ADDR_W+1), so DEPTH is reported exactly when full.
REQ-021 full = (occupancy == DEPTH); empty = (occupancy == 0); almost_full = (occupancy >= AF_LEVEL); almost_empty = (occupancy <= AE_LEVEL). All SHALL derive from registered pointers only.
REQ-022 Write selection: if wr_a_en, the word is wr_a_data; else if wr_b_en, wr_b_data; source A has priority.
REQ-023 If both wr_a_en and wr_b_en are high in one cycle, the source B word SHALL be dropped and conflict set.
REQ-024 A read is accepted when rd_en is high and empty is low; the read pointer increments by one at the clock edge.
REQ-025 A write is accepted when either enable is high and (full is low, or an accepted read occurs in the same cycle); the word is stored at wr_ptr and wr_ptr increments.
REQ-026 When full, a simultaneous read and write SHALL both be accepted; occupancy stays DEPTH.
REQ-027 When empty, a simultaneous read and write: the write is accepted, the read is rejected, and underflow is set.
REQ-028 A write request rejected because of full SHALL set overflow; storage and pointers are unchanged.
REQ-029 rd_en while empty SHALL set underflow; the pointers are unchanged.
REQ-030 Latency: a word written into an empty FIFO SHALL appear on rd_data, with empty low, in the cycle after the write edge.
REQ-031 Pointers SHALL wrap naturally from all-ones to zero with no discontinuity in occupancy.
REQ-032 flush SHALL have priority over reads and writes: at the edge both pointers go to 0 and the same-cycle read and write are ignored. Storage contents are not cleared. Error flags are not affected.
REQ-033 Sticky flags SHALL hold until clear_err. If clear_err and a new error event occur in the same cycle, the flag SHALL be set.

Reset
REQ-034 On rst high, asynchronously: pointers = 0, all storage words = 0, overflow/underflow/conflict = 0.
REQ-035 Resulting output values during reset: occupancy = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, rd_data = 0.
REQ-036 Reset asserted mid-operation SHALL discard all contents with no partial write; operation resumes on the first clock edge after rst is released.

Verification
REQ-037 Fill: 64 writes via A of 0x00..0x3F at defaults -> occupancy 64, full=1, almost_full asserted at 56; a 65th write -> overflow=1, contents unchanged.
REQ-038 Drain after fill: 64 reads -> rd_data sequence 0x00..0x3F, empty=1 at end; extra rd_en -> underflow=1.
REQ-039 Full with simultaneous rd_en and wr_a_en of 0xAA -> occupancy stays 64, no overflow, 0xAA is read last.
REQ-040 wr_a_en=0x11 and wr_b_en=0x22 in the same cycle on an empty FIFO -> next cycle rd_data=0x11, occupancy=1, conflict=1.
REQ-041 Wrap: 200 interleaved write/read pairs with random gaps -> data order preserved, occupancy never exceeds 64, pointer MSB toggles.
REQ-042 Reset checks:
- flush at occupancy 30 with a concurrent write -> next cycle occupancy 0, empty=1.
- rst mid-burst -> all REQ-035 values hold immediately, without waiting for a clock edge.
